// File: rtl/tt_mux_sel_driver.sv
// Self-timed sequencer for the tile mux selector: reset, N increment pulses, then enable.
// Optional MUX_SEL_FAST_PATH_EN: step forward from the current selection instead of resetting.
module tt_mux_sel_driver #(
    parameter int ADDR_W    = 10,
    parameter int RST_CYC   = 4,
    parameter int PULSE_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);
    localparam int MAXC  = (RST_CYC > PULSE_CYC) ? RST_CYC : PULSE_CYC;
    localparam int TMR_W = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, SEL_RST, GAP, INC_HI, INC_LO, ENABLE} state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              sel_rst_n_q, sel_rst_n_d;
    logic              inc_q, inc_d;
    logic              ena_q, ena_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              fast;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            cur_addr_q  <= '0;
            sel_rst_n_q <= 1'b0;
            inc_q       <= 1'b0;
            ena_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            cur_addr_q  <= cur_addr_d;
            sel_rst_n_q <= sel_rst_n_d;
            inc_q       <= inc_d;
            ena_q       <= ena_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

`ifdef MUX_SEL_FAST_PATH_EN
    // Selector only trusted if it was not left in reset; it can only count upward.
    assign fast = sel_rst_n_q && (req_addr >= cur_addr_q);
`else
    assign fast = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    if (fast) begin
                        cnt_d   = req_addr - cur_addr_q;
                        tmr_d   = TMR_W'(PULSE_CYC - 1);
                        state_d = (req_addr == cur_addr_q) ? ENABLE : INC_HI;
                    end else begin
                        cnt_d   = req_addr;
                        tmr_d   = TMR_W'(RST_CYC - 1);
                        state_d = SEL_RST;
                    end
                end
            end
            SEL_RST: begin
                tmr_d = tmr_q - TMR_W'(1);
                if (tmr_q == '0) begin
                    tmr_d   = TMR_W'(PULSE_CYC - 1);
                    state_d = GAP;
                end
            end
            GAP, INC_LO: begin
                tmr_d = tmr_q - TMR_W'(1);
                if (tmr_q == '0) begin
                    tmr_d   = TMR_W'(PULSE_CYC - 1);
                    state_d = (cnt_q == '0) ? ENABLE : INC_HI;
                end
            end
            INC_HI: begin
                tmr_d = tmr_q - TMR_W'(1);
                if (tmr_q == '0) begin
                    tmr_d   = TMR_W'(PULSE_CYC - 1);
                    cnt_d   = cnt_q - ADDR_W'(1);
                    state_d = INC_LO;
                end
            end
            ENABLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        sel_rst_n_d = sel_rst_n_q;
        case (state_d)
            IDLE:    sel_rst_n_d = sel_rst_n_q;
            SEL_RST: sel_rst_n_d = 1'b0;
            default: sel_rst_n_d = 1'b1;
        endcase
        inc_d      = (state_d == INC_HI);
        done_d     = (state_d == ENABLE);
        busy_d     = (state_d != IDLE);
        ready_d    = (state_d == IDLE);
        ena_d      = (state_d == ENABLE) || ((state_d == IDLE) && ena_q);
        cur_addr_d = (state_d == ENABLE) ? addr_d : cur_addr_q;
    end

    assign req_ready      = ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign cur_addr       = cur_addr_q;
    assign ctrl_sel_rst_n = sel_rst_n_q;
    assign ctrl_sel_inc   = inc_q;
    assign ctrl_ena       = ena_q;
endmodule

// File: tb/tb_tt_mux_sel_driver.sv
// Scoreboard bench for tt_mux_sel_driver (RST_CYC=4, PULSE_CYC=2, ADDR_W=10).
module tb_tt_mux_sel_driver;
    localparam int ADDR_W = 10;
    localparam int PC     = 2;
`ifdef MUX_SEL_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              busy, done, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;
    logic [ADDR_W-1:0] cur_addr;

    tt_mux_sel_driver #(.ADDR_W(ADDR_W), .RST_CYC(4), .PULSE_CYC(PC)) dut (
        .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .busy(busy), .done(done), .cur_addr(cur_addr),
        .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int cyc;
        int np;
        int nrl;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: counts selector activity per request and checks it when done fires.
    int n_inc, n_rl, run;
    bit inc_prev, busy_prev, bad_w, overlap;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            inc_prev  = 1'b0;
            busy_prev = 1'b0;
        end else begin
            if (busy && !busy_prev) begin
                n_inc = 0; n_rl = 0; run = 0; bad_w = 1'b0; overlap = 1'b0;
            end
            if (!ctrl_sel_rst_n) n_rl++;
            if (!ctrl_sel_rst_n && ctrl_sel_inc) overlap = 1'b1;
            if (ctrl_sel_inc) begin
                if (!inc_prev) n_inc++;
                run++;
            end else begin
                if (inc_prev && run != PC) bad_w = 1'b1;
                run = 0;
            end
            inc_prev  = ctrl_sel_inc;
            busy_prev = busy;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("cur_addr", cur_addr, e.addr);
                    chk("ena_at_done", ctrl_ena, 1);
                    chk("busy_at_done", busy, 1);
                    chk("inc_pulses", n_inc, e.np);
                    chk("rst_low_cycles", n_rl, e.nrl);
                    chk("inc_width_bad", bad_w, 0);
                    chk("rst_inc_overlap", overlap, 0);
                end
            end
        end
    end

    task automatic issue(input int a, input int lat, input int np, input int nrl, input bit push);
        int i;
        for (i = 0; i < 50 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!req_ready) chk("ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_addr  = ADDR_W'(a);
        if (push) sb.push_back('{addr: a, cyc: cyc + lat, np: np, nrl: nrl});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 6000 && (busy || !req_ready); i++) begin
            @(posedge clk); #1;
        end
        if (busy || !req_ready) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_sel_rst_n", ctrl_sel_rst_n, 0);
        chk("rst_inc", ctrl_sel_inc, 0);
        chk("rst_ena", ctrl_ena, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_addr", cur_addr, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", req_ready, 1);

        // Full path, A=3 then A=0 (A<C forces full path even with the fast option)
        issue(3, 19, 3, 4, 1'b1); wait_idle();
        issue(0, 7, 0, 4, 1'b1);  wait_idle();

        // Busy requests ignored; only the first address counts
        issue(6, FAST ? 25 : 31, 6, FAST ? 0 : 4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_addr  = ADDR_W'(20 + i);
            chk("ready_while_busy", req_ready, 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        wait_idle();
        chk("ena_held_idle", ctrl_ena, 1);
        chk("cur_addr_held", cur_addr, 6);

        // Reset in the 2nd INC_HI of A=5 (starts cycle t+11; we are at t+1)
        issue(5, 0, 0, 0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_inc_high", ctrl_sel_inc, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_sel_rst_n", ctrl_sel_rst_n, 0);
        chk("mid_rst_inc", ctrl_sel_inc, 0);
        chk("mid_rst_ena", ctrl_ena, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cur_addr", cur_addr, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        issue(2, 15, 2, 4, 1'b1); wait_idle();

        // Forward steps (fast path when enabled), max address, A=C, then A<C
        issue(3, FAST ? 5 : 19, FAST ? 1 : 3, FAST ? 0 : 4, 1'b1);  wait_idle();
        issue(5, FAST ? 9 : 27, FAST ? 2 : 5, FAST ? 0 : 4, 1'b1);  wait_idle();
        issue(1023, FAST ? 4073 : 4099, FAST ? 1018 : 1023, FAST ? 0 : 4, 1'b1); wait_idle();
        issue(1023, FAST ? 1 : 4099, FAST ? 0 : 1023, FAST ? 0 : 4, 1'b1);       wait_idle();
        issue(1, 11, 1, 4, 1'b1); wait_idle();

        repeat (5) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
